// File: rtl/weight_update_pkg.sv
// Shared definitions for the weight-update sequencer: FSM encoding and default geometry.
package weight_update_pkg;
  localparam int N_DEF     = 8;
  localparam int ROWS_DEF  = 4;
  localparam int COLS_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_PE = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } wu_state_e;
endpackage

// File: rtl/weight_update_sched_if.sv
// Capture strobe and prefetcher handshake between the sequencer and the update buffer side.
interface weight_update_sched_if #(parameter int ROWS = 4);
  localparam int RW = $clog2(ROWS);

  logic          cap_en;
  logic [RW-1:0] cap_row;
  logic          pref_valid;
  logic          pref_ready;
  logic [RW-1:0] pref_row;

  modport master (output cap_en, cap_row, pref_valid, pref_row, input pref_ready);
  modport slave  (input cap_en, cap_row, pref_valid, pref_row, output pref_ready);
endinterface

// File: rtl/weight_update_sched_row_counter.sv
// Row index shared by capture and drain; clr wins over inc, wraps to 0 after ROWS-1.
module wu_row_counter #(
  parameter int ROWS = 4,
  localparam int RW  = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] cnt,
  output logic [RW-1:0] cnt_nxt,
  output logic          last
);
  assign last = (cnt == RW'(ROWS-1));

  always_comb begin
    cnt_nxt = cnt;
    if (clr)      cnt_nxt = '0;
    else if (inc) cnt_nxt = last ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt_nxt;
  end
endmodule

// File: rtl/weight_update_sched.sv
// Weight-update sequencer: waits for PE array, strobes ROWS captures, drains ROWS rows to the prefetcher.
module weight_update_sched
  import weight_update_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 pe_done,
  weight_update_sched_if.master wu,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [CNT_W-1:0]     pass_cnt
);
  localparam int RW = $clog2(ROWS);

  if (ROWS < 2 || N * COLS < 1) begin : g_param_chk
    $error("weight_update_sched: ROWS must be >= 2 and N*COLS must be positive");
  end

  wu_state_e     state;
  logic          cap_en_q, pref_valid_q;
  logic [RW-1:0] cap_row_q, pref_row_q;
  logic [RW-1:0] cnt, cnt_nxt;
  logic          last, cnt_clr, cnt_inc, xfer;

  assign xfer = pref_valid_q & wu.pref_ready;

  // Counter sits at 0 outside CAPTURE/DRAIN, so each phase starts from row 0.
  always_comb begin
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    if (state == ST_CAPTURE) begin
      cnt_clr = 1'b0;
      cnt_inc = 1'b1;
    end else if (state == ST_DRAIN) begin
      cnt_clr = 1'b0;
      cnt_inc = xfer;
    end
  end

  wu_row_counter #(.ROWS(ROWS)) u_row_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cap_en_q     <= 1'b0;
      cap_row_q    <= '0;
      pref_valid_q <= 1'b0;
      pref_row_q   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      pass_cnt     <= '0;
    end else begin
      cap_en_q <= 1'b0;
      done     <= 1'b0;
      // pe_done is never queued outside WAIT_PE; flag it for software instead.
      if (pe_done && (state == ST_CAPTURE || state == ST_DRAIN || state == ST_DONE))
        overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_WAIT_PE;
            busy  <= 1'b1;
          end
        end
        ST_WAIT_PE: begin
          if (!en) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (pe_done) begin
            state     <= ST_CAPTURE;
            cap_en_q  <= 1'b1;
            cap_row_q <= '0;
          end
        end
        ST_CAPTURE: begin
          if (last) begin
            state        <= ST_DRAIN;
            cap_row_q    <= '0;
            pref_valid_q <= 1'b1;
            pref_row_q   <= '0;
          end else begin
            cap_en_q  <= 1'b1;
            cap_row_q <= cnt_nxt;
          end
        end
        ST_DRAIN: begin
          if (xfer) begin
            if (last) begin
              state        <= ST_DONE;
              pref_valid_q <= 1'b0;
              pref_row_q   <= '0;
              done         <= 1'b1;
              if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            end else begin
              pref_row_q <= cnt_nxt;
            end
          end
        end
        ST_DONE: begin
          if (en) begin
            state <= ST_WAIT_PE;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wu.cap_en     = cap_en_q;
  assign wu.cap_row    = cap_row_q;
  assign wu.pref_valid = pref_valid_q;
  assign wu.pref_row   = pref_row_q;
endmodule

// File: tb/tb_weight_update_sched.sv
// Directed bench for weight_update_sched: vector table for a nominal pass plus corner-case sequences.
module tb_weight_update_sched;
  localparam int ROWS  = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0, pe_done = 1'b0, rdy = 1'b0;
  logic busy, done, overrun;
  logic [CNT_W-1:0] pass_cnt;
  logic s_busy, s_done, s_overrun;
  logic [1:0] s_pass_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_update_sched_if #(.ROWS(ROWS)) wif ();
  weight_update_sched_if #(.ROWS(ROWS)) sif ();
  assign wif.pref_ready = rdy;
  assign sif.pref_ready = rdy;

  weight_update_sched #(.ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .pe_done(pe_done), .wu(wif),
    .busy(busy), .done(done), .overrun(overrun), .pass_cnt(pass_cnt)
  );

  // Narrow counter copy to reach saturation in a few passes.
  weight_update_sched #(.ROWS(ROWS), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .pe_done(pe_done), .wu(sif),
    .busy(s_busy), .done(s_done), .overrun(s_overrun), .pass_cnt(s_pass_cnt)
  );

  typedef struct {
    logic       en, pd, rdy;
    logic [8:0] exp;
    logic [15:0] cnt;
  } vec_t;

  function automatic logic [8:0] pk(input logic ce, input logic [1:0] cr, input logic pv,
                                    input logic [1:0] pr, input logic b, input logic d, input logic o);
    return {ce, cr, pv, pr, b, d, o};
  endfunction

  function automatic logic [8:0] outs();
    return {wif.cap_en, wif.cap_row, wif.pref_valid, wif.pref_row, busy, done, overrun};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic p, input logic r);
    en = e; pe_done = p; rdy = r;
    @(posedge clk); #1;
  endtask

  // Called in WAIT_PE with en=1; returns capture count and cycle of done relative to pe_done edge.
  task automatic run_pass(input int drop_at, input int pd_at, output int caps, output int done_at);
    int c;
    caps = 0; done_at = -1;
    step(1'b1, 1'b1, 1'b1);
    c = 1;
    while (c <= 40 && done_at < 0) begin
      caps += int'(wif.cap_en);
      if (done) done_at = c;
      else begin
        step((drop_at < 0 || c < drop_at), (c == pd_at), 1'b1);
        c++;
      end
    end
    if (done_at < 0) chk("pass_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[13];
    int caps, dat;

    vt[0]  = '{1, 0, 1, pk(0, 0, 0, 0, 1, 0, 0), 0};
    vt[1]  = '{1, 1, 1, pk(1, 0, 0, 0, 1, 0, 0), 0};
    vt[2]  = '{1, 0, 1, pk(1, 1, 0, 0, 1, 0, 0), 0};
    vt[3]  = '{1, 0, 1, pk(1, 2, 0, 0, 1, 0, 0), 0};
    vt[4]  = '{1, 0, 1, pk(1, 3, 0, 0, 1, 0, 0), 0};
    vt[5]  = '{1, 0, 1, pk(0, 0, 1, 0, 1, 0, 0), 0};
    vt[6]  = '{1, 0, 1, pk(0, 0, 1, 1, 1, 0, 0), 0};
    vt[7]  = '{1, 0, 1, pk(0, 0, 1, 2, 1, 0, 0), 0};
    vt[8]  = '{1, 0, 1, pk(0, 0, 1, 3, 1, 0, 0), 0};
    vt[9]  = '{1, 0, 1, pk(0, 0, 0, 0, 1, 1, 0), 1};
    vt[10] = '{0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0), 1};
    // pe_done on the IDLE->WAIT_PE entry cycle must not start a capture.
    vt[11] = '{1, 1, 1, pk(0, 0, 0, 0, 1, 0, 0), 1};
    vt[12] = '{1, 0, 1, pk(0, 0, 0, 0, 1, 0, 0), 1};

    reset_n = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("reset_outs", 32'(outs()), 0);
    chk("reset_cnt", 32'(pass_cnt), 0);
    reset_n = 1'b1;

    step(0, 1, 1);
    chk("idle_pd_ignored", 32'(outs()), 0);

    for (int i = 0; i < 13; i++) begin
      step(vt[i].en, vt[i].pd, vt[i].rdy);
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vt[i].exp));
      chk($sformatf("vec%0d_cnt", i), 32'(pass_cnt), 32'(vt[i].cnt));
    end

    // Stall on row 1 for three cycles.
    step(1, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    chk("stall_cap3", 32'({wif.cap_en, wif.cap_row}), 32'({1'b1, 2'd3}));
    step(1, 0, 1);
    step(1, 0, 1);
    chk("stall_pre", 32'({wif.pref_valid, wif.pref_row}), 32'({1'b1, 2'd1}));
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk($sformatf("stall_hold%0d", i), 32'({wif.pref_valid, wif.pref_row, done}), 32'({1'b1, 2'd1, 1'b0}));
    end
    step(1, 0, 1);
    chk("stall_row2", 32'({wif.pref_valid, wif.pref_row}), 32'({1'b1, 2'd2}));
    step(1, 0, 1);
    chk("stall_row3", 32'({wif.pref_valid, wif.pref_row}), 32'({1'b1, 2'd3}));
    step(1, 0, 1);
    chk("stall_done", 32'({done, wif.pref_valid}), 32'({1'b1, 1'b0}));
    chk("stall_cnt", 32'(pass_cnt), 2);

    // en dropped in WAIT_PE.
    step(1, 0, 1);
    chk("wait_busy", 32'(busy), 1);
    step(0, 0, 1);
    chk("wait_drop", 32'({busy, done, wif.cap_en}), 0);
    chk("wait_drop_cnt", 32'(pass_cnt), 2);

    // en dropped in DRAIN: pass still completes.
    step(1, 0, 1);
    run_pass(6, -1, caps, dat);
    chk("drain_drop_caps", 32'(caps), 4);
    chk("drain_drop_done_at", 32'(dat), 9);
    step(0, 0, 1);
    chk("drain_drop_idle", 32'({busy, overrun}), 0);
    chk("drain_drop_cnt", 32'(pass_cnt), 3);

    // pe_done during CAPTURE sets sticky overrun.
    step(1, 0, 1);
    run_pass(-1, 2, caps, dat);
    chk("ovr_caps", 32'(caps), 4);
    chk("ovr_done_at", 32'(dat), 9);
    chk("ovr_flag", 32'(overrun), 1);
    step(0, 0, 1);
    chk("ovr_sticky", 32'({overrun, busy}), 32'({1'b1, 1'b0}));
    chk("ovr_cnt", 32'(pass_cnt), 4);

    // Reset mid-DRAIN on row 2.
    step(1, 0, 1);
    step(1, 1, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0 == 1 ? 0 : 1);
    chk("rst_pre_row2", 32'({wif.pref_valid, wif.pref_row}), 32'({1'b1, 2'd2}));
    reset_n = 1'b0;
    step(1, 0, 1);
    chk("rst_outs", 32'(outs()), 0);
    chk("rst_cnt", 32'(pass_cnt), 0);
    chk("rst_sat_cnt", 32'({s_pass_cnt, s_overrun}), 0);
    reset_n = 1'b1;
    step(0, 0, 1);
    chk("rst_idle", 32'(busy), 0);

    // Saturation on the narrow counter; done keeps pulsing.
    step(1, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      run_pass(-1, -1, caps, dat);
      chk($sformatf("sat%0d_done_at", k), 32'(dat), 9);
      chk($sformatf("sat%0d_sdone", k), 32'(s_done), 1);
      chk($sformatf("sat%0d_scnt", k), 32'(s_pass_cnt), (k > 3) ? 3 : k);
      chk($sformatf("sat%0d_cnt", k), 32'(pass_cnt), k);
      step(1, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
